cv32e40x_alu_iter: RTL
======================

// Module: cv32e40x_alu_iter
// PURPOSE
// - Multi-cycle companion to the single-cycle ALU. Computes carry-less multiply (CLMUL/CLMULH/CLMULR) and CPOP iteratively.
// - Processes STEP bits of the operand per cycle, which removes the large combinational clmul/popcount cone from EX.
// - Sits beside the ALU in EX. Uses a valid/ready handshake towards the EX controller and supports kill on flush.
// PARAMETERS
// - WIDTH       32  datapath width; legal values are 32 or 64.
// - STEP        4   operand bits consumed per cycle; power of 2, 1..WIDTH, divides WIDTH. N = WIDTH/STEP.
// - EARLY_TERM  1   1: finish as soon as the remaining operand bits are all zero; 0: always run N cycles.
// PORTS
// - clk        in   1      clock
// - rst_n      in   1      reset, synchronous, active-low
// - valid_i    in   1      operation request
// - ready_o    out  1      unit can accept a request (state IDLE)
// - op_i       in   2      alu_iter_op_e: CLMUL=0, CLMULH=1, CLMULR=2, CPOP=3
// - operand_a  in   WIDTH  operand a
// - operand_b  in   WIDTH  operand b (ignored for CPOP)
// - kill_i     in   1      synchronous abort of any in-flight operation
// - valid_o    out  1      result available
// - ready_i    in   1      consumer accepts the result
// - result_o   out  WIDTH  registered result
// BEHAVIOUR
// - Reset (rst_n low at a clk edge): state=IDLE, valid_o=0, result_o=0, counter=0, accumulators=0. Reset has priority over everything, including in BUSY/DONE.
// - ready_o = (state==IDLE), combinational. Accept = valid_i && ready_o && !kill_i.
// - On accept, capture op, a_sh={WIDTH'0,a} (2*WIDTH wide), b_sh (b, or a for CPOP), acc=0, cnt=0. Inputs may change afterwards.
// - FSM:
//   - IDLE -accept-> BUSY.
//   - BUSY: each cycle processes one chunk.
//     - clmul: for k<STEP, if b_sh[k] then acc ^= a_sh<<k; then a_sh<<=STEP, b_sh>>=STEP, cnt++.
//     - CPOP: acc += popcount(b_sh[STEP-1:0]); b_sh>>=STEP.
//   - BUSY->DONE when cnt==N-1, or when EARLY_TERM && (b_sh>>STEP)==0. Minimum BUSY time is 1 cycle.
//   - On entering DONE, result_o is loaded; valid_o=1.
//     - CLMUL: acc[WIDTH-1:0]
//     - CLMULH: acc[2W-1:W]
//     - CLMULR: acc[2W-2:W-1]
//     - CPOP: zero-extended count; width is clog2(WIDTH)+1.
//   - DONE -(ready_i)-> IDLE. valid_o falls the next cycle and result_o holds its value.
// - Latency: handshake in cycle t; valid_o rises at t+N+1 (full run) or t+k+1 after k BUSY cycles (early termination).
// - Backpressure: while valid_o && !ready_i, result_o and valid_o stay stable and ready_o=0. No overlap; a new accept happens at the earliest one cycle after the DONE handshake.
// - kill_i:
//   - In any state, the next state is IDLE and valid_o=0 next cycle; result_o is unchanged.
//   - kill_i in the same cycle as valid_i prevents the accept.
//   - kill_i in DONE with ready_i high is a plain return to IDLE.
// - Arithmetic: the clmul accumulator is 2*WIDTH wide and never truncated before the final select. CLMULH bit W-1 is always 0.
// - cnt width is max(1,$clog2(N)). With N=1, every operation finishes after 1 BUSY cycle.
// - op_i values outside the enum cannot occur (2-bit encoding is full).
// STRUCTURE
// - cv32e40x_pkg: typedef enum logic[1:0] alu_iter_op_e; typedef enum logic[1:0] alu_iter_state_e {IDLE,BUSY,DONE}.
// - Sub-module cv32e40x_alu_iter_step (combinational, parameters WIDTH and STEP):
//   - inputs: op, a_sh, b_sh chunk, acc
//   - output: next acc
//   - contains the per-chunk clmul XOR tree and the STEP-bit popcount.
// - Top level contains the FSM, counter, shift registers, result select and registers.
// TESTING
// - W=32,S=4,ET=0: CLMUL a=0x3,b=0x8000_0001 at t -> valid_o at t+9, result_o=0x8000_0003. CLMULH same operands -> 0x1.
// - CLMULH a=b=0x8000_0000 -> 0x4000_0000. CLMULR same operands -> 0x8000_0000. CLMUL -> 0x0.
// - ET=1: CPOP a=0xFFFF_FFFF -> 32 at t+9. CPOP a=0 -> 0 at t+2. CLMUL a=0x5,b=0x3 -> 0xF at t+2.
// - Backpressure: ready_i=0 for 5 cycles in DONE -> valid_o=1, result_o and ready_o=0 all stable; ready_i=1 -> IDLE, ready_o=1 next cycle.
// - kill_i in 3rd BUSY cycle -> valid_o never rises, ready_o=1 next cycle. A following CLMUL 0x3*0x3 gives 0x5. kill_i with valid_i in IDLE -> no accept.
// - rst_n low for 1 cycle mid-BUSY and again in DONE -> valid_o=0, result_o=0, ready_o=1 after release. W=64,S=8 CLMULH a=b=2^63 -> 0x4000_0000_0000_0000.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// Shared types for the iterative ALU: operation encoding and FSM states.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    CLMUL  = 2'd0,
    CLMULH = 2'd1,
    CLMULR = 2'd2,
    CPOP   = 2'd3
  } alu_iter_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_iter_state_e;

endpackage

// File: rtl/cv32e40x_alu_iter_step.sv
// One iteration of the multi-cycle ALU: folds STEP operand bits into the
// accumulator, either as a carry-less partial product or as a popcount.
module cv32e40x_alu_iter_step
  import cv32e40x_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic [1:0]         op,
  input  logic [2*WIDTH-1:0] a_sh,
  input  logic [STEP-1:0]    b_chunk,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] acc_next
);

  localparam int PCW = $clog2(STEP) + 1;

  logic [PCW-1:0]     pop;
  logic [2*WIDTH-1:0] xor_sum;

  always_comb begin
    pop     = '0;
    xor_sum = acc;
    for (int k = 0; k < STEP; k++) begin
      pop = pop + PCW'(b_chunk[k]);
      if (b_chunk[k]) begin
        xor_sum = xor_sum ^ (a_sh << k);
      end
    end
  end

  assign acc_next = (alu_iter_op_e'(op) == CPOP) ? acc + (2*WIDTH)'(pop) : xor_sum;

endmodule

// File: rtl/cv32e40x_alu_iter.sv
// Iterative CLMUL/CLMULH/CLMULR/CPOP unit beside the EX-stage ALU, with
// valid/ready handshakes on both sides and a synchronous kill.
module cv32e40x_alu_iter
  import cv32e40x_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STEP       = 4,
  parameter int EARLY_TERM = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int N   = WIDTH / STEP;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int CPW = $clog2(WIDTH) + 1;

  alu_iter_state_e    state;
  alu_iter_op_e       op_q;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               accept;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   b_rest;
  logic               last;
  logic [WIDTH-1:0]   res_sel;

  assign ready_o = (state == IDLE);
  assign accept  = valid_i && ready_o && !kill_i;
  assign b_rest  = b_sh >> STEP;
  assign last    = (cnt == CW'(N - 1)) || ((EARLY_TERM != 0) && (b_rest == '0));

  cv32e40x_alu_iter_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) step_i (
    .op       (op_q),
    .a_sh     (a_sh),
    .b_chunk  (b_sh[STEP-1:0]),
    .acc      (acc),
    .acc_next (acc_next)
  );

  // Result is selected from the accumulator value of the final chunk so it
  // can be registered on the same edge that enters DONE.
  always_comb begin
    res_sel = acc_next[WIDTH-1:0];
    case (op_q)
      CLMULH:  res_sel = acc_next[2*WIDTH-1:WIDTH];
      CLMULR:  res_sel = acc_next[2*WIDTH-2:WIDTH-1];
      CPOP:    res_sel = WIDTH'(acc_next[CPW-1:0]);
      default: res_sel = acc_next[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= CLMUL;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      cnt      <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else if (kill_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= alu_iter_op_e'(op_i);
            a_sh  <= {{WIDTH{1'b0}}, operand_a};
            b_sh  <= (alu_iter_op_e'(op_i) == CPOP) ? operand_a : operand_b;
            acc   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc  <= acc_next;
          a_sh <= a_sh << STEP;
          b_sh <= b_rest;
          cnt  <= cnt + CW'(1);
          if (last) begin
            state    <= DONE;
            valid_o  <= 1'b1;
            result_o <= res_sel;
          end
        end
        DONE: begin
          if (ready_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
